dfmul_seq: RTL and testbench
============================

// Module: dfmul_seq
// PURPOSE
//  Digit-serial BCD mantissa multiplier primitive; counterpart to the decimal divider in the DFPU.
//  Forms the full 2N-digit packed-BCD product p = a*b by shift-and-repeated-add, MS digit of b first.
//  Sits under the decimal-float multiply wrapper, which handles sign, exponent and rounding.
//  Also reports the product's leading-zero digit count for the wrapper's normaliser.
// PARAMETERS
//  N      33   mantissa digits per operand; FPWID = 4*N bits
// PORTS
//  clk    in   1        clock, all state updates on rising edge
//  rst_n  in   1        asynchronous reset, active low
//  ld     in   1        load operands and start; sampled each clk
//  a      in   4N       multiplicand, packed BCD
//  b      in   4N       multiplier, packed BCD
//  p      out  8N       product, packed BCD; registered
//  done   out  1        product valid; registered level
//  lzcnt  out  8        leading zero digits of p, binary count 0..2N; combinational from p
// BEHAVIOUR
//  Reset, async while rst_n=0: st=IDLE, p=0, done=0, acc=0, ai=0, bi=0, dg=0, dcnt=0. lzcnt follows p, so it reads 2N.
//  Registers: acc[8N] accumulator; ai[4N] latched a; bi[4N] shift copy of b; dg[4] current digit; dcnt digits left.
//  ld has priority over every state, including mid-operation.
//    On each clk with ld=1: ai<=a, bi<=b, acc<=0, dcnt<=N-1, done<=0, st<=SHFT.
//    p keeps its old value until the next DONE.
//  States IDLE, SHFT, ADDN, DONE:
//   IDLE: hold. done=0 from reset.
//   SHFT: acc<=acc<<4 (x10); dg<=bi[4N-1:4N-4]; bi<=bi<<4; st<=ADDN.
//   ADDN, dg!=0: acc<=BCD(acc + {0,ai}); dg<=dg-1.
//   ADDN, dg==0 and dcnt!=0: dcnt<=dcnt-1; st<=SHFT.
//   ADDN, dg==0 and dcnt==0: st<=DONE.
//   DONE: p<=acc; done<=1; stay in DONE until ld.
//  Latency: the load edge is edge 0; done rises at edge 2N+S+1, where S = sum of the digits of b.
//   Range: 2N+1 (b=0) to 11N+1 (b all 9s).
//  Arithmetic: 8N-bit decimal add with carry chain; the final carry out is provably 0 and is dropped.
//   The acc<<4 discards the top digit, which is provably 0.
//  Non-BCD digits on a or b: result undefined. No error flag.
//  lzcnt: count of zero digits scanned from p[8N-1:8N-4] down to the first nonzero digit; 2N when p=0.
//  Reset mid-operation aborts immediately; no partial product reaches p.
//  ld on the same edge that DONE would be entered: the load wins and done stays 0.
// STRUCTURE
//  Shared package dfpu_pkg:
//   localparam DIGW=4.
//   typedef enum logic[1:0] {IDLE,SHFT,ADDN,DONE} dfmul_st_t.
//   function lzd_cnt for the digit scan, shared with dfdiv normalisation.
//  One sub-module: bcd_add_comb #(.N(2*N)) ua1 (.a(acc), .b({ai_hi0,ai}), .ci(1'b0), .o(sum), .co()).
//   Purely combinational per-digit add with +6 correction. FSM, counters and lzcnt stay in dfmul_seq.
// TESTING  (bench at N=4 unless noted; clk period 10)
//  rst_n=0 for 3 clks -> p=0, done=0, lzcnt=8; release with ld=0 -> IDLE held, done stays 0.
//  a=16'h1234, b=16'h5678, ld for 1 clk -> done at edge 35, p=32'h07006652, lzcnt=1; done held until next ld.
//  a=16'h9999, b=16'h9999 -> done at edge 45, p=32'h99980001, lzcnt=0 (max latency, carry-chain stress).
//  a=16'h4321, b=16'h0000 -> done at edge 9, p=0, lzcnt=8.
//  Start 1234*5678, reassert ld at edge 10 with a=16'h0005, b=16'h0005 -> done at edge 10+14, p=32'h00000025, lzcnt=6.
//  Start 9999*9999, pulse rst_n=0 at edge 20 -> p=0, done=0 immediately; new ld -> correct result.
//  N=33 smoke: a=1, b=all 9s (33 nines) -> p = 33 nines in the low 33 digits, lzcnt=33, done at edge 364.

Source files
------------

// File: rtl/dfpu_pkg.sv
// Shared DFPU definitions: digit width, multiplier FSM states and the
// leading-zero-digit scan used by the multiply and divide normalisers.
package dfpu_pkg;

  localparam int unsigned DIGW     = 4;
  localparam int unsigned LZD_MAXD = 128;
  localparam int unsigned LZD_W    = DIGW * LZD_MAXD;

  typedef enum logic [1:0] {IDLE, SHFT, ADDN, DONE} dfmul_st_t;

  // Counts zero digits from digit ndig-1 downward; callers zero-extend to LZD_W.
  function automatic logic [7:0] lzd_cnt(input logic [LZD_W-1:0] v, input int unsigned ndig);
    logic [7:0] cnt;
    logic       found;
    cnt   = '0;
    found = 1'b0;
    for (int unsigned i = LZD_MAXD; i > 0; i--) begin
      if ((i <= ndig) && !found) begin
        if (v[DIGW*(i-1) +: DIGW] != '0) found = 1'b1;
        else                             cnt   = cnt + 8'd1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bcd_add_comb.sv
// Combinational N-digit packed-BCD adder: ripple carry per digit with +6 correction.
module bcd_add_comb #(
  parameter int unsigned N = 8
) (
  input  logic [4*N-1:0] a,
  input  logic [4*N-1:0] b,
  input  logic           ci,
  output logic [4*N-1:0] o,
  output logic           co
);

  always_comb begin
    logic       c;
    logic [4:0] s;
    o = '0;
    c = ci;
    s = '0;
    for (int unsigned i = 0; i < N; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      o[4*i +: 4] = s[3:0];
    end
    co = c;
  end

endmodule

// File: rtl/dfmul_seq.sv
// Digit-serial BCD mantissa multiplier: p = a*b by shift-and-repeated-add,
// most significant multiplier digit first, plus leading-zero digit count of p.
module dfmul_seq
  import dfpu_pkg::*;
#(
  parameter int unsigned N = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [4*N-1:0]   a,
  input  logic [4*N-1:0]   b,
  output logic [8*N-1:0]   p,
  output logic             done,
  output logic [7:0]       lzcnt
);

  localparam int unsigned W    = DIGW * N;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  dfmul_st_t       st_q, st_d;
  logic [2*W-1:0]  acc_q, acc_d, p_q, p_d, sum;
  logic [W-1:0]    ai_q, ai_d, bi_q, bi_d;
  logic [3:0]      dg_q, dg_d;
  logic [CntW-1:0] dcnt_q, dcnt_d;
  logic            done_q, done_d;

  bcd_add_comb #(.N(2*N)) ua1 (
    .a  (acc_q),
    .b  ({{W{1'b0}}, ai_q}),
    .ci (1'b0),
    .o  (sum),
    .co ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      acc_q  <= '0;
      ai_q   <= '0;
      bi_q   <= '0;
      dg_q   <= '0;
      dcnt_q <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      acc_q  <= acc_d;
      ai_q   <= ai_d;
      bi_q   <= bi_d;
      dg_q   <= dg_d;
      dcnt_q <= dcnt_d;
      p_q    <= p_d;
      done_q <= done_d;
    end
  end

  // Load overrides every state, including an operation in flight.
  always_comb begin
    st_d = st_q;
    if (ld) begin
      st_d = SHFT;
    end else begin
      unique case (st_q)
        IDLE: st_d = IDLE;
        SHFT: st_d = ADDN;
        ADDN: if (dg_q == 4'd0) st_d = (dcnt_q == '0) ? DONE : SHFT;
        DONE: st_d = DONE;
        default: st_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d  = acc_q;
    ai_d   = ai_q;
    bi_d   = bi_q;
    dg_d   = dg_q;
    dcnt_d = dcnt_q;
    p_d    = p_q;
    done_d = done_q;
    if (ld) begin
      ai_d   = a;
      bi_d   = b;
      acc_d  = '0;
      dcnt_d = CntW'(N - 1);
      done_d = 1'b0;
    end else begin
      unique case (st_q)
        SHFT: begin
          // Top digit of acc is always zero here, so the x10 shift loses nothing.
          acc_d = {acc_q[2*W-5:0], 4'h0};
          dg_d  = bi_q[W-1 -: 4];
          bi_d  = {bi_q[W-5:0], 4'h0};
        end
        ADDN: begin
          if (dg_q != 4'd0) begin
            acc_d = sum;
            dg_d  = dg_q - 4'd1;
          end else if (dcnt_q != '0) begin
            dcnt_d = dcnt_q - CntW'(1);
          end
        end
        DONE: begin
          p_d    = acc_q;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign p    = p_q;
  assign done = done_q;

  always_comb begin
    lzcnt = lzd_cnt(LZD_W'(p_q), 2 * N);
  end

endmodule

// File: tb/tb_dfmul_seq.sv
// Self-checking bench for dfmul_seq: N=4 instance driven through a scoreboard,
// plus an N=33 instance for a single full-width smoke case.
module tb_dfmul_seq;

  typedef struct {
    logic [31:0] p;
    logic [7:0]  lz;
    int          lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ld = 1'b0;
  logic [15:0]  a = '0, b = '0;
  logic [31:0]  p;
  logic         done;
  logic [7:0]   lzcnt;

  logic         ld33 = 1'b0;
  logic [131:0] a33 = '0, b33 = '0;
  logic [263:0] p33;
  logic         done33;
  logic [7:0]   lz33;

  int   cyc = 0;
  int   load_edge = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dfmul_seq #(.N(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld),
    .a     (a),
    .b     (b),
    .p     (p),
    .done  (done),
    .lzcnt (lzcnt)
  );

  dfmul_seq #(.N(33)) u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld33),
    .a     (a33),
    .b     (b33),
    .p     (p33),
    .done  (done33),
    .lzcnt (lz33)
  );

  function automatic longint bcd2int(input logic [15:0] v);
    longint r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input longint x);
    logic [31:0] r = '0;
    longint      t = x;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] lz_model(input logic [31:0] v);
    int c = 0;
    for (int i = 7; i >= 0; i--) begin
      if (v[4*i +: 4] != 4'd0) break;
      c++;
    end
    return 8'(c);
  endfunction

  function automatic int dsum(input logic [15:0] v);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(v[4*i +: 4]);
    return s;
  endfunction

  // Called at a negedge; returns at the negedge after the load edge.
  task automatic start_op(input logic [15:0] aa, input logic [15:0] bb);
    exp_t e;
    e.p   = int2bcd(bcd2int(aa) * bcd2int(bb));
    e.lz  = lz_model(e.p);
    e.lat = 2 * 4 + dsum(bb) + 1;
    sb.push_back(e);
    ld = 1'b1;
    a  = aa;
    b  = bb;
    @(negedge clk);
    load_edge = cyc;
    ld = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    exp_t e;
    int   n = 0;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb: scoreboard empty, got nothing expected an entry", nm);
      return;
    end
    e = sb.pop_front();
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, expected 1", nm, done, n);
      return;
    end
    if (cyc - load_edge !== e.lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", nm, cyc - load_edge, e.lat);
    end
    checks++;
    if (p !== e.p) begin
      errors++;
      $display("FAIL %s_p: got %h expected %h", nm, p, e.p);
    end
    checks++;
    if (lzcnt !== e.lz) begin
      errors++;
      $display("FAIL %s_lzcnt: got %0d expected %0d", nm, lzcnt, e.lz);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (p !== 32'h0) begin errors++; $display("FAIL rst_p: got %h expected 0", p); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (lzcnt !== 8'd8) begin errors++; $display("FAIL rst_lzcnt: got %0d expected 8", lzcnt); end
    checks++; if (lz33 !== 8'd66) begin errors++; $display("FAIL rst_lz33: got %0d expected 66", lz33); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_done: got %b expected 0", done); end
  endtask

  task automatic test_basic();
    start_op(16'h1234, 16'h5678);
    wait_done("basic");
    repeat (5) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done: got %b expected 1", done); end
    checks++; if (p !== 32'h07006652) begin errors++; $display("FAIL hold_p: got %h expected 07006652", p); end
  endtask

  task automatic test_max();
    start_op(16'h9999, 16'h9999);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL max_ld_done: got %b expected 0", done); end
    checks++; if (p !== 32'h07006652) begin errors++; $display("FAIL max_p_kept: got %h expected 07006652", p); end
    wait_done("max");
  endtask

  task automatic test_zero_b();
    start_op(16'h4321, 16'h0000);
    wait_done("zero_b");
  endtask

  task automatic test_reload();
    start_op(16'h1234, 16'h5678);
    repeat (9) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reload_busy: got %b expected 0", done); end
    sb.delete();
    start_op(16'h0005, 16'h0005);
    wait_done("reload");
  endtask

  task automatic test_ld_on_done();
    start_op(16'h0005, 16'h0005);
    repeat (12) @(negedge clk);
    sb.delete();
    start_op(16'h0002, 16'h0003);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ld_on_done: got %b expected 0", done); end
    checks++; if (p !== 32'h00000025) begin errors++; $display("FAIL ld_on_done_p: got %h expected 00000025", p); end
    wait_done("ld_on_done");
  endtask

  task automatic test_reset_abort();
    start_op(16'h9999, 16'h9999);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (p !== 32'h0) begin errors++; $display("FAIL abort_p: got %h expected 0", p); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    start_op(16'h0012, 16'h0034);
    wait_done("after_abort");
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra, rb;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      start_op(ra, rb);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b expected 0", done); end
      wait_done("b2b");
    end
  endtask

  task automatic test_smoke33();
    logic [263:0] ep;
    int           n = 0;
    int           l33;
    ep = '0;
    a33 = 132'd1;
    for (int i = 0; i < 33; i++) begin
      b33[4*i +: 4] = 4'h9;
      ep[4*i +: 4]  = 4'h9;
    end
    ld33 = 1'b1;
    @(negedge clk);
    l33  = cyc;
    ld33 = 1'b0;
    while (!done33 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done33) begin
      errors++;
      $display("FAIL n33_timeout: done=%b expected 1", done33);
      return;
    end
    if (cyc - l33 !== 364) begin
      errors++;
      $display("FAIL n33_latency: got %0d expected 364", cyc - l33);
    end
    checks++; if (p33 !== ep) begin errors++; $display("FAIL n33_p: got %h expected %h", p33, ep); end
    checks++; if (lz33 !== 8'd33) begin errors++; $display("FAIL n33_lzcnt: got %0d expected 33", lz33); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero_b();
    test_reload();
    test_ld_on_done();
    test_reset_abort();
    test_back_to_back();
    test_smoke33();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
